// File: rtl/fifo_pkg.sv
// Shared constants and operation classification for the synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEFAULT = 8;
    localparam int FIFO_DEPTH_DEFAULT = 32;

    // Encoding is {read accepted, write accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } op_e;

    function automatic op_e classify_op(input logic wr_acc, input logic rd_acc);
        return op_e'({rd_acc, wr_acc});
    endfunction

endpackage

// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fifo
    import fifo_pkg::*;
#(
    parameter  int WIDTH     = FIFO_WIDTH_DEFAULT,
    parameter  int DEPTH     = FIFO_DEPTH_DEFAULT,
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     din,
    output logic                 full,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   count
);

    localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 wr_acc;
    logic                 rd_acc;
    op_e                  op;
    logic [PTR_WIDTH:0]   count_next;

    // Acceptance depends only on the registered flags, so a write while full
    // or a read while empty is dropped regardless of the other request.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;
    assign op     = classify_op(wr_acc, rd_acc);

    always_comb begin
        count_next = count;
        case (op)
            OP_WRITE: count_next = count + CNT_ONE;
            OP_READ:  count_next = count - CNT_ONE;
            default:  count_next = count;
        endcase
    end

    // Storage carries no reset so it can map onto plain register/RAM resources.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            dout   <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

endmodule
